// File: rtl/inst_cache_pkg.sv
// Shared geometry defaults and FSM state type for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int unsigned ICACHE_INDEX_BITS  = 6;
  localparam int unsigned ICACHE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    ICACHE_IDLE,
    ICACHE_LOOKUP,
    ICACHE_MISS,
    ICACHE_REFILL,
    ICACHE_UNC_REQ,
    ICACHE_UNC_WAIT
  } icache_state_t;

endpackage

// File: rtl/icache_ram.sv
// Data + tag store: one synchronous full-line read port, one line-wide write port.
module icache_ram #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 22,
  parameter int unsigned LINE_BITS  = 128
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] raddr,
  output logic [LINE_BITS-1:0]  rline,
  output logic [TAG_BITS-1:0]   rtag,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic [LINE_BITS-1:0]  wline,
  input  logic [TAG_BITS-1:0]   wtag
);

  logic [LINE_BITS-1:0] data_mem [2**INDEX_BITS];
  logic [TAG_BITS-1:0]  tag_mem  [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[waddr] <= wline;
      tag_mem[waddr]  <= wtag;
    end
    if (re) begin
      rline <= data_mem[raddr];
      rtag  <= tag_mem[raddr];
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between Fetch (sram-like) and the AXI bridge inst port.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_uncache,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_uncache,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WORD_BITS  = OFFSET_BITS - 2;
  localparam int unsigned LINE_WORDS = 2**WORD_BITS;
  localparam int unsigned CNT_BITS   = WORD_BITS + 1;
  localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINES      = 2**INDEX_BITS;

  icache_state_t state, state_nx;

  logic [31:0]                  req_addr;
  logic                         req_unc;
  logic [LINES-1:0]             valid;
  logic [CNT_BITS-1:0]          req_cnt, rsp_cnt;
  logic [LINE_WORDS-1:0][31:0]  line_buf, fill_line, ram_line;
  logic [TAG_BITS-1:0]          ram_tag;
  logic                         flush_pend;
  logic                         hit, accept, last_rsp;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [WORD_BITS-1:0]  req_word;
  logic                  unused_inputs;

  assign req_tag  = req_addr[31 -: TAG_BITS];
  assign req_idx  = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_word = req_addr[2 +: WORD_BITS];
  assign unused_inputs = ^{cpu_wr, cpu_size};

  assign mem_wr    = 1'b0;
  assign mem_size  = 2'b10;
  assign mem_wdata = '0;

  assign hit         = (state == ICACHE_LOOKUP) && valid[req_idx] && (ram_tag == req_tag);
  assign cpu_addr_ok = resetn && !flush && !flush_pend && ((state == ICACHE_IDLE) || hit);
  assign accept      = cpu_req && cpu_addr_ok;
  assign last_rsp    = (state == ICACHE_MISS) && mem_data_ok &&
                       (rsp_cnt == CNT_BITS'(LINE_WORDS - 1));

  // Responses arrive in order, so the final beat always lands in the top word.
  always_comb begin
    fill_line = line_buf;
    fill_line[LINE_WORDS-1] = mem_rdata;
  end

  icache_ram #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (LINE_WORDS*32)
  ) u_ram (
    .clk  (clk),
    .re   (accept),
    .raddr(cpu_addr[OFFSET_BITS +: INDEX_BITS]),
    .rline(ram_line),
    .rtag (ram_tag),
    .we   (last_rsp),
    .waddr(req_idx),
    .wline(fill_line),
    .wtag (req_tag)
  );

  always_comb begin
    state_nx    = state;
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    mem_uncache = 1'b0;
    case (state)
      ICACHE_IDLE: begin
        if (accept) state_nx = cpu_uncache ? ICACHE_UNC_REQ : ICACHE_LOOKUP;
      end
      ICACHE_LOOKUP: begin
        if (hit) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = ram_line[req_word];
          if (accept) state_nx = cpu_uncache ? ICACHE_UNC_REQ : ICACHE_LOOKUP;
          else        state_nx = ICACHE_IDLE;
        end else begin
          state_nx = ICACHE_MISS;
        end
      end
      ICACHE_MISS: begin
        if (req_cnt < CNT_BITS'(LINE_WORDS)) begin
          mem_req  = 1'b1;
          mem_addr = {req_tag, req_idx, req_cnt[WORD_BITS-1:0], 2'b00};
        end
        if (last_rsp) state_nx = ICACHE_REFILL;
      end
      ICACHE_REFILL: begin
        cpu_data_ok = 1'b1;
        cpu_rdata   = line_buf[req_word];
        state_nx    = ICACHE_IDLE;
      end
      ICACHE_UNC_REQ: begin
        mem_req     = 1'b1;
        mem_addr    = req_addr;
        mem_uncache = req_unc;
        if (mem_addr_ok) state_nx = ICACHE_UNC_WAIT;
      end
      ICACHE_UNC_WAIT: begin
        if (mem_data_ok) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = mem_rdata;
          state_nx    = ICACHE_IDLE;
        end
      end
      default: state_nx = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ICACHE_IDLE;
      req_addr   <= '0;
      req_unc    <= 1'b0;
      valid      <= '0;
      req_cnt    <= '0;
      rsp_cnt    <= '0;
      line_buf   <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_addr <= cpu_addr;
        req_unc  <= cpu_uncache;
      end
      if ((state == ICACHE_LOOKUP) && !hit) begin
        req_cnt <= '0;
        rsp_cnt <= '0;
      end
      if (state == ICACHE_MISS) begin
        if (mem_req && mem_addr_ok) req_cnt <= req_cnt + 1'b1;
        if (mem_data_ok) begin
          line_buf[rsp_cnt[WORD_BITS-1:0]] <= mem_rdata;
          rsp_cnt <= rsp_cnt + 1'b1;
        end
      end
      if (last_rsp) valid[req_idx] <= 1'b1;
      // A flush seen outside IDLE is deferred, so an in-flight refill is dropped once it lands.
      if ((state == ICACHE_IDLE) && (flush || flush_pend)) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache with a randomly delayed sram-like memory model.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_size = 2'b10;
  logic [31:0] cpu_addr = '0;
  logic        cpu_uncache = 1'b0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        flush = 1'b0;
  logic        mem_req, mem_wr, mem_uncache;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  inst_cache #(.INDEX_BITS(6), .OFFSET_BITS(4)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_uncache(cpu_uncache), .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
    .cpu_rdata(cpu_rdata), .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_uncache(mem_uncache), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_n = 0;
  int acc_dly = -1;
  int rsp_dly = -1;
  logic [31:0] exp_q[$];
  int          data_cyc[$];
  logic [32:0] mem_log[$];
  logic [31:0] rsp_q[$];

  function automatic logic [31:0] memval(input logic [31:0] a);
    logic [31:0] w;
    w = {30'd0, a[3:2]};
    if (a[31:4] == 28'h1C00000) return 32'hA0 + w;
    if (a[31:4] == 28'h1C00040) return 32'hB0 + w;
    if (a == 32'h1FE00000)      return 32'hC0;
    return 32'hDEAD0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory: accepts and answers with 0-5 cycle random delays, data strictly after acceptance.
  always begin
    @(posedge clk);
    #1;
    if (!resetn) begin
      rsp_q.delete();
      acc_dly = -1;
      rsp_dly = -1;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
    end else begin
      mem_data_ok = 1'b0;
      if (rsp_q.size() != 0) begin
        if (rsp_dly < 0) rsp_dly = $urandom_range(0, 5);
        if (rsp_dly == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata = memval(rsp_q.pop_front());
          rsp_n++;
          rsp_dly = -1;
        end else rsp_dly--;
      end
      mem_addr_ok = 1'b0;
      if (mem_req) begin
        if (acc_dly < 0) acc_dly = $urandom_range(0, 5);
        if (acc_dly == 0) begin
          mem_addr_ok = 1'b1;
          rsp_q.push_back(mem_addr);
          mem_log.push_back({mem_uncache, mem_addr});
          acc_dly = -1;
        end else acc_dly--;
      end
    end
  end

  // Monitor: every data_ok pops the oldest expected word.
  always @(negedge clk) begin
    if (resetn && cpu_data_ok) begin
      data_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_data_ok actual=%h expected=none", cpu_rdata);
      end else begin
        chk("rdata", cpu_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic u, input logic [31:0] e, output int waited);
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_addr = a;
    cpu_uncache = u;
    waited = 0;
    forever begin
      @(negedge clk);
      if (cpu_addr_ok) begin
        exp_q.push_back(e);
        acc_cyc = cyc;
        break;
      end
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no_addr_ok expected=addr_ok addr=%h", a);
        break;
      end
    end
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a, input logic u, input logic [31:0] e);
    int w;
    fetch(a, u, e, w);
    release_req();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_log(input string name, input int n, input logic [31:0] base, input logic unc);
    chk({name, "_reqs"}, mem_log.size(), n);
    for (int i = 0; i < n && i < mem_log.size(); i++) begin
      chk({name, "_addr"}, mem_log[i][31:0], base + 32'(4 * i));
      chk({name, "_unc"}, {31'd0, mem_log[i][32]}, {31'd0, unc});
    end
    mem_log.delete();
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_addr_ok"}, {31'd0, cpu_addr_ok}, 0);
    chk({name, "_data_ok"}, {31'd0, cpu_data_ok}, 0);
    chk({name, "_rdata"}, cpu_rdata, 0);
    chk({name, "_mem_req"}, {31'd0, mem_req}, 0);
    chk({name, "_mem_addr"}, mem_addr, 0);
    chk({name, "_mem_unc"}, {31'd0, mem_uncache}, 0);
  endtask

  initial begin
    int w0, w1, w2, w3, base_n;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: cold miss then hit
    fetch1(32'h1C000000, 1'b0, 32'hA0);
    drain();
    chk_log("cold_miss", 4, 32'h1C000000, 1'b0);
    fetch1(32'h1C000008, 1'b0, 32'hA2);
    drain();
    chk("hit_latency", data_cyc[$] - acc_cyc, 1);
    chk_log("hit", 0, '0, 1'b0);

    // 2: back-to-back hits
    fetch(32'h1C000000, 1'b0, 32'hA0, w0);
    fetch(32'h1C000004, 1'b0, 32'hA1, w1);
    fetch(32'h1C000008, 1'b0, 32'hA2, w2);
    fetch(32'h1C00000C, 1'b0, 32'hA3, w3);
    release_req();
    drain();
    chk("b2b_waits", w0 + w1 + w2 + w3, 0);
    chk("b2b_consecutive", data_cyc[$] - data_cyc[data_cyc.size() - 4], 3);
    chk_log("b2b", 0, '0, 1'b0);

    // 3: conflict on index 0
    fetch1(32'h1C000400, 1'b0, 32'hB0);
    drain();
    chk_log("conflict", 4, 32'h1C000400, 1'b0);
    fetch1(32'h1C000000, 1'b0, 32'hA0);
    drain();
    chk_log("conflict_back", 4, 32'h1C000000, 1'b0);

    // 4: uncached bypass, twice, resident line untouched
    fetch1(32'h1FE00000, 1'b1, 32'hC0);
    drain();
    chk_log("unc1", 1, 32'h1FE00000, 1'b1);
    fetch1(32'h1FE00000, 1'b1, 32'hC0);
    drain();
    chk_log("unc2", 1, 32'h1FE00000, 1'b1);
    fetch1(32'h1C000004, 1'b0, 32'hA1);
    drain();
    chk_log("after_unc_hit", 0, '0, 1'b0);

    // 5: flush during MISS, then flush with accept in IDLE
    fetch1(32'h1C000014, 1'b0, 32'hDEAD0014);
    for (int i = 0; i < 100 && !mem_req; i++) @(negedge clk);
    chk("miss_mem_req", {31'd0, mem_req}, 1);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    drain();
    chk_log("flush_miss", 4, 32'h1C000010, 1'b0);
    fetch1(32'h1C000014, 1'b0, 32'hDEAD0014);
    drain();
    chk_log("after_flush", 4, 32'h1C000010, 1'b0);
    fetch1(32'h1C000000, 1'b0, 32'hA0);
    drain();
    chk_log("after_flush_l0", 4, 32'h1C000000, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 32'h1C000014;
    cpu_uncache = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept", {31'd0, cpu_addr_ok}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    fetch1(32'h1C000014, 1'b0, 32'hDEAD0014);
    drain();
    chk_log("idle_flush", 4, 32'h1C000010, 1'b0);

    // 6: reset after two of four refill responses
    base_n = rsp_n;
    fetch1(32'h1C000020, 1'b0, 32'hDEAD0020);
    for (int i = 0; i < 200 && rsp_n < base_n + 2; i++) @(negedge clk);
    chk("two_responses", rsp_n - base_n, 2);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mem_log.delete();
    repeat (2) @(negedge clk);
    fetch1(32'h1C000020, 1'b0, 32'hDEAD0020);
    drain();
    chk_log("post_reset", 4, 32'h1C000020, 1'b0);
    fetch1(32'h1C000000, 1'b0, 32'hA0);
    drain();
    chk_log("post_reset_l0", 4, 32'h1C000000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
